// File: rtl/lam_pkg.sv
// Shared definitions for the load/store access unit: funct3 encodings,
// instruction class, lam_control field layout and FSM state encoding.
package lam_pkg;

  localparam logic STORE_INST = 1'b1;
  localparam logic LOAD_INST  = 1'b0;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // lam_control = {is_store, funct3, reg}
  localparam int CTRL_ST_BIT = 8;
  localparam int CTRL_F3_LSB = 5;
  localparam int CTRL_RD_LSB = 0;

  // state   | meaning
  // IDLE    | waiting for lam_new
  // REQ     | memory request outstanding, waiting for mem_ack
  // WB      | load result registered, writeback strobe this cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WB   = 2'd2
  } lam_state_e;

endpackage

// File: rtl/lam_unit_if.sv
// Data-memory req/ack port. The access unit is the master, memory the slave.
interface lam_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lam_align.sv
// Byte-lane logic for the access unit: legality check and store lane
// replication/strobes on the issue side, lane select and extension on the
// load-return side. Purely combinational, 32-bit data only.
module lam_align
  import lam_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [31:0] store_data_i,
  output logic        legal_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lsb_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane_w;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Access legality from instruction class, width and alignment
  always_comb begin
    legal_o = 1'b0;
    case (funct3_i)
      F3_B:    legal_o = 1'b1;
      F3_H:    legal_o = ~addr_lsb_i[0];
      F3_W:    legal_o = (addr_lsb_i == 2'b00);
      F3_BU:   legal_o = (is_store_i == LOAD_INST);
      F3_HU:   legal_o = (is_store_i == LOAD_INST) & ~addr_lsb_i[0];
      default: legal_o = 1'b0;
    endcase
  end

  // Store data replicated across lanes so memory only needs the strobes
  always_comb begin
    wdata_o = store_data_i;
    wstrb_o = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_o = {4{store_data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lsb_i;
      end
      2'b01: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = addr_lsb_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign lane_w = rdata_i >> {ld_addr_lsb_i, 3'b000};
  assign lane_b = lane_w[7:0];
  assign lane_h = lane_w[15:0];

  // Load result: selected lane, sign- or zero-extended
  always_comb begin
    ld_data_o = rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    ld_data_o = {{16{lane_h[15]}}, lane_h};
      F3_BU:   ld_data_o = {24'b0, lane_b};
      F3_HU:   ld_data_o = {16'b0, lane_h};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lam_unit.sv
// Load/store access unit: one memory transaction per lam_new, load
// formatting and register-bank writeback, busy stall towards issue.
module lam_unit
  import lam_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lam_new,
  input  logic [8:0]        lam_control,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              busy,
  lam_unit_if.master        mem,
  output logic              wb_valid,
  output logic [4:0]        wb_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_misaligned
);

  lam_state_e        state_q, state_d;
  logic              is_store_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, wb_data_q;
  logic [3:0]        wstrb_q;
  logic              err_q, err_d;
  logic              capture, wb_load;

  logic              legal;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [3:0]        st_wstrb;

  lam_align u_align (
    .is_store_i    (lam_control[CTRL_ST_BIT]),
    .funct3_i      (lam_control[CTRL_F3_LSB +: 3]),
    .addr_lsb_i    (alu_addr[1:0]),
    .store_data_i  (store_data),
    .legal_o       (legal),
    .wdata_o       (st_wdata),
    .wstrb_o       (st_wstrb),
    .ld_funct3_i   (f3_q),
    .ld_addr_lsb_i (addr_q[1:0]),
    .rdata_i       (mem.mem_rdata),
    .ld_data_o     (ld_data)
  );

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and capture/writeback enables
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    wb_load = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lam_new) begin
          capture = 1'b1;
          if (legal) state_d = ST_REQ;
          else       err_d   = 1'b1;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          if (is_store_q == STORE_INST) begin
            state_d = ST_IDLE;
          end else begin
            wb_load = 1'b1;
            state_d = ST_WB;
          end
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Captured access context and registered load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      f3_q       <= 3'b0;
      rd_q       <= 5'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= 4'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (capture) begin
        is_store_q <= lam_control[CTRL_ST_BIT];
        f3_q       <= lam_control[CTRL_F3_LSB +: 3];
        rd_q       <= lam_control[CTRL_RD_LSB +: 5];
        addr_q     <= alu_addr;
        wdata_q    <= st_wdata;
        wstrb_q    <= (lam_control[CTRL_ST_BIT] == STORE_INST) ? st_wstrb : 4'b0;
      end
      if (wb_load) wb_data_q <= ld_data;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign mem.mem_req    = (state_q == ST_REQ);
  assign mem.mem_we     = mem.mem_req & is_store_q;
  assign mem.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.mem_wdata  = wdata_q;
  assign mem.mem_wstrb  = wstrb_q;
  assign wb_valid       = (state_q == ST_WB) && (rd_q != 5'd0);
  assign wb_sel         = rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_lam_unit.sv
// Bench for lam_unit: directed scenarios plus randomized loads/stores with
// random memory latency, stray acks and issue attempts while busy.
module tb_lam_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lam_new = 1'b0;
  logic [8:0]  lam_control = '0;
  logic [31:0] alu_addr = '0;
  logic [31:0] store_data = '0;
  logic        busy, wb_valid, err_misaligned;
  logic [4:0]  wb_sel;
  logic [31:0] wb_data;

  lam_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  lam_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lam_new        (lam_new),
    .lam_control    (lam_control),
    .alu_addr       (alu_addr),
    .store_data     (store_data),
    .busy           (busy),
    .mem            (mif),
    .wb_valid       (wb_valid),
    .wb_sel         (wb_sel),
    .wb_data        (wb_data),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  // expected DUT outputs for the current cycle
  bit          chk_en = 0;
  bit          exp_busy, exp_req, exp_we, exp_err, exp_wbv, exp_rstv;
  logic [31:0] exp_addr, exp_wdata, exp_wb_data;
  logic [3:0]  exp_wstrb;
  logic [4:0]  exp_wb_sel;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference model: access rules as plain arithmetic ----
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    if (n == 0) return 0;
    if (st && f3[2]) return 0;
    return (int'(a[1:0]) % n) == 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    if (n == 1) return (d & 32'hFF) * 32'h01010101;
    if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    int lane = int'(a[1:0]);
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] r);
    int lane = int'(a[1:0]);
    logic [31:0] v = r >> (8 * lane);
    case (f3)
      3'b000: begin v = v & 32'hFF;   if (v[7])  v = v | 32'hFFFFFF00; end
      3'b100: v = v & 32'hFF;
      3'b001: begin v = v & 32'hFFFF; if (v[15]) v = v | 32'hFFFF0000; end
      3'b101: v = v & 32'hFFFF;
      default: v = r;
    endcase
    return v;
  endfunction

  // Compare DUT outputs against the expected values each cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     32'(busy),           32'(exp_busy));
      chk("mem_req",  32'(mif.mem_req),    32'(exp_req));
      chk("err",      32'(err_misaligned), 32'(exp_err));
      chk("wb_valid", 32'(wb_valid),       32'(exp_wbv));
      if (exp_req) begin
        chk("mem_we",    32'(mif.mem_we),    32'(exp_we));
        chk("mem_addr",  mif.mem_addr,       exp_addr);
        chk("mem_wdata", mif.mem_wdata,      exp_wdata);
        chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_wstrb));
      end
      if (exp_wbv) begin
        chk("wb_sel",  32'(wb_sel), 32'(exp_wb_sel));
        chk("wb_data", wb_data,     exp_wb_data);
      end
      if (exp_rstv) begin
        chk("rst_we",    32'(mif.mem_we),    32'd0);
        chk("rst_addr",  mif.mem_addr,       32'd0);
        chk("rst_wdata", mif.mem_wdata,      32'd0);
        chk("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
        chk("rst_wbsel", 32'(wb_sel),        32'd0);
        chk("rst_wbdat", wb_data,            32'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    exp_busy = 0; exp_req = 0; exp_err = 0; exp_wbv = 0; exp_we = 0;
  endtask

  task automatic poke_new();
    lam_new     = 1'b1;
    lam_control = 9'($urandom);
    alu_addr    = $urandom;
    store_data  = $urandom;
  endtask

  // One access: wait cycles before ack, load return word, issue attempts while busy
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] d, input int w,
                           input logic [31:0] rword, input bit poke);
    lam_new = 1'b1; lam_control = {st, f3, rd}; alu_addr = a; store_data = d;
    cyc();
    lam_new = 1'b0; alu_addr = $urandom; store_data = $urandom; lam_control = 9'($urandom);
    set_idle();
    if (!m_legal(st, f3, a)) begin
      exp_err = 1;
      cyc();
      set_idle();
      return;
    end
    exp_busy = 1; exp_req = 1; exp_we = st; exp_addr = a & ~32'h3;
    exp_wdata = st ? m_wdata(f3, d) : exp_wdata;
    exp_wstrb = st ? m_wstrb(f3, a) : 4'b0000;
    if (!st) exp_wdata = mif.mem_wdata;  // write data is don't-care for loads
    for (int i = 0; i < w; i++) begin
      mif.mem_ack = 1'b0;
      if (poke && i == 0) poke_new();
      cyc();
      lam_new = 1'b0;
    end
    if (poke && w == 0) poke_new();
    mif.mem_ack = 1'b1; mif.mem_rdata = rword;
    cyc();
    lam_new = 1'b0; mif.mem_ack = 1'b0; mif.mem_rdata = $urandom;
    set_idle();
    if (!st) begin
      exp_busy = 1; exp_wbv = (rd != 5'd0); exp_wb_sel = rd;
      exp_wb_data = m_load(f3, a, rword);
      if (poke) poke_new();
      cyc();
      lam_new = 1'b0;
      set_idle();
    end
  endtask

  // Idle cycles with stray acks that must be ignored
  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      mif.mem_ack = 1'($urandom); mif.mem_rdata = $urandom;
      cyc();
    end
    mif.mem_ack = 1'b0;
  endtask

  initial begin
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    set_idle(); exp_rstv = 1;
    exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_wb_sel = '0; exp_wb_data = '0;
    cyc();
    chk_en = 1;
    cyc();
    rst_n = 1'b1;
    cyc();
    exp_rstv = 0;

    // hand-computed values pinning the model
    chk("pin_lb",   m_load(3'b000, 32'h203, 32'h80FFFFFF), 32'hFFFFFF80);
    chk("pin_lbu",  m_load(3'b100, 32'h203, 32'h80FFFFFF), 32'h00000080);
    chk("pin_lh",   m_load(3'b001, 32'h002, 32'h8001_1234), 32'hFFFF8001);
    chk("pin_shd",  m_wdata(3'b001, 32'h0000ABCD), 32'hABCDABCD);
    chk("pin_shs",  32'(m_wstrb(3'b001, 32'h302)), 32'h0000000C);
    chk("pin_sbs",  32'(m_wstrb(3'b000, 32'h101)), 32'h00000002);
    chk("pin_lwmis", 32'(m_legal(0, 3'b010, 32'h401)), 32'd0);
    chk("pin_f3011", 32'(m_legal(0, 3'b011, 32'h400)), 32'd0);
    chk("pin_sbu",   32'(m_legal(1, 3'b100, 32'h400)), 32'd0);

    // directed scenarios
    do_access(1, 3'b010, 5'd3, 32'h100, 32'hDEADBEEF, 2, 32'h0, 0);
    idle_gap(1);
    do_access(0, 3'b000, 5'd5, 32'h203, 32'h0, 0, 32'h80FFFFFF, 0);
    do_access(0, 3'b100, 5'd5, 32'h203, 32'h0, 0, 32'h80FFFFFF, 0);
    do_access(1, 3'b001, 5'd0, 32'h302, 32'h0000ABCD, 1, 32'h0, 0);
    do_access(0, 3'b010, 5'd4, 32'h401, 32'h0, 0, 32'h0, 0);
    do_access(0, 3'b011, 5'd4, 32'h400, 32'h0, 0, 32'h0, 0);
    do_access(0, 3'b010, 5'd0, 32'h500, 32'h0, 2, 32'h12345678, 1);
    idle_gap(2);

    // reset while a request is outstanding; a late ack must be dropped
    lam_new = 1'b1; lam_control = {1'b0, 3'b010, 5'd7}; alu_addr = 32'h600;
    cyc();
    lam_new = 1'b0;
    set_idle(); exp_busy = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h600;
    exp_wdata = mif.mem_wdata; exp_wstrb = 4'b0000;
    rst_n = 1'b0;
    cyc();
    set_idle(); exp_rstv = 1;
    rst_n = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
    cyc();
    mif.mem_ack = 1'b0;
    cyc();
    exp_rstv = 0;

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      bit          st = 1'($urandom);
      logic [2:0]  f3;
      logic [31:0] a = $urandom;
      logic [4:0]  rd = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom);
      if ($urandom % 6 == 0)  f3 = 3'($urandom);
      else if (st)            f3 = 3'($urandom % 3);
      else                    f3 = ld_f3s[$urandom % 5];
      if ($urandom % 4 != 0) begin
        if (nbytes(f3) == 4)      a = a & ~32'h3;
        else if (nbytes(f3) == 2) a = a & ~32'h1;
      end
      do_access(st, f3, rd, a, $urandom, int'($urandom % 4), $urandom, 1'($urandom));
      idle_gap(int'($urandom % 3));
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
